// File: rtl/nes_pad_reader_if.sv
// Pin and decoded-button bundle between the NES pad reader and its consumers.
// master = reader side (drives strobes and decoded outputs), slave = pads/consumer side.
interface nes_pad_reader_if #(
  parameter int NUM_PADS = 1
);
  logic [NUM_PADS-1:0]   nes_data;
  logic                  nes_latch;
  logic                  nes_clk;
  logic [8*NUM_PADS-1:0] buttons;
  logic                  buttons_valid;
  logic [8*NUM_PADS-1:0] pressed;
  logic                  mux_select;
  logic                  select_out;

  modport master (
    input  nes_data,
    output nes_latch, nes_clk, buttons, buttons_valid, pressed, mux_select, select_out
  );

  modport slave (
    output nes_data,
    input  nes_latch, nes_clk, buttons, buttons_valid, pressed, mux_select, select_out
  );
endinterface

// File: rtl/nes_pad_reader.sv
// Self-timed NES pad poller: latch/clock generation, serial capture, press-edge decode.
// Frame is 16*CLK_DIV+9 cycles after POLL_CYCLES idle; outputs update the cycle after DONE, no backpressure.
module nes_pad_reader #(
  parameter int NUM_PADS    = 1,
  parameter int CLK_DIV     = 300,
  parameter int POLL_CYCLES = 833333
) (
  input  logic               clk,
  input  logic               reset_n,
  nes_pad_reader_if.master   bus
);

  localparam int LATCH_CYC = 2 * CLK_DIV;
  localparam int CNT_MAX   = (LATCH_CYC > POLL_CYCLES) ? LATCH_CYC : POLL_CYCLES;
  localparam int CW        = $clog2(CNT_MAX + 1);

  localparam logic [CW-1:0] POLL_LAST  = CW'(POLL_CYCLES - 1);
  localparam logic [CW-1:0] LATCH_LAST = CW'(LATCH_CYC - 1);
  localparam logic [CW-1:0] DIV_LAST   = CW'(CLK_DIV - 1);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    LATCH  = 3'd1,
    SAMPLE = 3'd2,
    CLK_HI = 3'd3,
    CLK_LO = 3'd4,
    DONE   = 3'd5
  } state_t;

  state_t                state, state_nxt;
  logic [CW-1:0]         cnt, cnt_nxt;
  logic [2:0]            bit_idx, bit_idx_nxt;
  logic [NUM_PADS-1:0]   sync1, sync2;
  logic [8*NUM_PADS-1:0] shift_r;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state   <= IDLE;
      cnt     <= '0;
      bit_idx <= '0;
    end else begin
      state   <= state_nxt;
      cnt     <= cnt_nxt;
      bit_idx <= bit_idx_nxt;
    end
  end

  // Each timed state ends when its phase counter reaches the last cycle.
  always_comb begin
    state_nxt   = state;
    cnt_nxt     = cnt + 1'b1;
    bit_idx_nxt = bit_idx;
    case (state)
      IDLE: begin
        if (cnt == POLL_LAST) begin
          state_nxt   = LATCH;
          cnt_nxt     = '0;
          bit_idx_nxt = '0;
        end
      end
      LATCH: begin
        if (cnt == LATCH_LAST) begin
          state_nxt = SAMPLE;
          cnt_nxt   = '0;
        end
      end
      SAMPLE: begin
        cnt_nxt = '0;
        if (bit_idx == 3'd7) begin
          state_nxt = DONE;
        end else begin
          bit_idx_nxt = bit_idx + 3'd1;
          state_nxt   = CLK_HI;
        end
      end
      CLK_HI: begin
        if (cnt == DIV_LAST) begin
          state_nxt = CLK_LO;
          cnt_nxt   = '0;
        end
      end
      CLK_LO: begin
        if (cnt == DIV_LAST) begin
          state_nxt = SAMPLE;
          cnt_nxt   = '0;
        end
      end
      DONE: begin
        state_nxt = IDLE;
        cnt_nxt   = '0;
      end
      default: begin
        state_nxt = IDLE;
        cnt_nxt   = '0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sync1 <= '0;
      sync2 <= '0;
    end else begin
      sync1 <= bus.nes_data;
      sync2 <= sync1;
    end
  end

  // Strobes are registered from the next state so they track the FSM without glitches.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      bus.nes_latch <= 1'b0;
      bus.nes_clk   <= 1'b0;
    end else begin
      bus.nes_latch <= (state_nxt == LATCH);
      bus.nes_clk   <= (state_nxt == CLK_HI);
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      shift_r <= '0;
    end else if (state == SAMPLE) begin
      for (int p = 0; p < NUM_PADS; p++) begin
        shift_r[8*p +: 8] <= {shift_r[8*p +: 7], ~sync2[p]};
      end
    end
  end

  // A takes priority over B; Select toggles only on a fresh press of pad 0.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      bus.buttons       <= '0;
      bus.pressed       <= '0;
      bus.buttons_valid <= 1'b0;
      bus.mux_select    <= 1'b0;
      bus.select_out    <= 1'b0;
    end else if (state == DONE) begin
      bus.buttons       <= shift_r;
      bus.pressed       <= shift_r & ~bus.buttons;
      bus.buttons_valid <= 1'b1;
      if (shift_r[7]) begin
        bus.mux_select <= 1'b0;
      end else if (shift_r[6]) begin
        bus.mux_select <= 1'b1;
      end
      bus.select_out <= bus.select_out ^ (shift_r[5] & ~bus.buttons[5]);
    end else begin
      bus.pressed       <= '0;
      bus.buttons_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_nes_pad_reader.sv
// Bench for nes_pad_reader: two pads (pad 1 can be disconnected), timing-level reference model
// checked every cycle, plus directed literal checks and randomized frames.
module tb_nes_pad_reader;
  localparam int NP  = 2;
  localparam int CD  = 2;
  localparam int PC  = 16;
  localparam int PER = PC + 16 * CD + 9;

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  always #5 clk = ~clk;

  nes_pad_reader_if #(.NUM_PADS(NP)) bus();

  nes_pad_reader #(
    .NUM_PADS(NP),
    .CLK_DIV(CD),
    .POLL_CYCLES(PC)
  ) dut (
    .clk(clk),
    .reset_n(reset_n),
    .bus(bus)
  );

  int n_cmp = 0;
  int n_bad = 0;

  task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Pad model: 4021-style shift register, output active-low, advanced by nes_clk rising edges.
  logic [7:0]   btn [NP];
  logic [7:0]   ld  [NP];
  logic [NP-1:0] conn;
  int           idx = 0;

  initial begin
    for (int p = 0; p < NP; p++) begin
      btn[p] = 8'h00;
      ld[p]  = 8'h00;
    end
    conn = 2'b01;
  end

  always @(posedge bus.nes_latch) begin
    for (int p = 0; p < NP; p++) ld[p] = btn[p];
    idx = 0;
  end

  always @(posedge bus.nes_clk) idx = idx + 1;

  always_comb begin
    for (int p = 0; p < NP; p++) begin
      bus.nes_data[p] = (conn[p] && idx < 8) ? ~ld[p][3'(7 - idx)] : 1'b1;
    end
  end

  // Cycles since reset release (rising edges seen with reset_n high).
  int n = 0;
  always @(posedge clk) begin
    if (!reset_n) n = 0;
    else n = n + 1;
  end

  // Reference model: frame timing from phase arithmetic, decoded outputs from frame captures.
  logic [15:0] e_btn = '0;
  logic [15:0] cap   = '0;
  logic        e_mux = 1'b0;
  logic        e_sel = 1'b0;

  always @(negedge clk) begin : model
    int ph, g, s;
    logic el, ec, ev;
    logic [15:0] ep;
    if (!reset_n) begin
      e_btn = '0;
      e_mux = 1'b0;
      e_sel = 1'b0;
      check("rst_latch", 16'(bus.nes_latch), 16'h0);
      check("rst_clk", 16'(bus.nes_clk), 16'h0);
      check("rst_buttons", bus.buttons, 16'h0);
      check("rst_pressed", bus.pressed, 16'h0);
      check("rst_valid", 16'(bus.buttons_valid), 16'h0);
      check("rst_mux", 16'(bus.mux_select), 16'h0);
      check("rst_sel", 16'(bus.select_out), 16'h0);
    end else begin
      ph = n % PER;
      el = (ph >= PC) && (ph < PC + 2 * CD);
      ec = 1'b0;
      g  = ph - PC - 2 * CD;
      if (g >= 0 && g < 7 * (2 * CD + 1)) begin
        s  = g % (2 * CD + 1);
        ec = (s >= 1) && (s <= CD);
      end
      if (ph == PC) cap = {conn[1] ? btn[1] : 8'h00, conn[0] ? btn[0] : 8'h00};
      ev = 1'b0;
      ep = '0;
      if (n > 0 && ph == 0) begin
        ev    = 1'b1;
        ep    = cap & ~e_btn;
        e_btn = cap;
        if (cap[7]) e_mux = 1'b0;
        else if (cap[6]) e_mux = 1'b1;
        if (ep[5]) e_sel = ~e_sel;
      end
      check("m_latch", 16'(bus.nes_latch), 16'(el));
      check("m_clk", 16'(bus.nes_clk), 16'(ec));
      check("m_valid", 16'(bus.buttons_valid), 16'(ev));
      check("m_buttons", bus.buttons, e_btn);
      check("m_pressed", bus.pressed, ep);
      check("m_mux", 16'(bus.mux_select), 16'(e_mux));
      check("m_sel", 16'(bus.select_out), 16'(e_sel));
    end
  end

  task automatic wait_update();
    bit ok;
    ok = 1'b0;
    for (int i = 0; i < 2 * PER; i++) begin
      @(negedge clk);
      if (bus.buttons_valid) begin
        ok = 1'b1;
        break;
      end
    end
    if (!ok) begin
      n_cmp++;
      n_bad++;
      $display("FAIL wait_update: no buttons_valid within %0d cycles", 2 * PER);
    end
  endtask

  initial begin : watchdog
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin : stim
    int cyc, hi, pul;
    bit prev, got;
    repeat (3) @(negedge clk);
    check("reset_buttons", bus.buttons, 16'h0);
    check("reset_latch", 16'(bus.nes_latch), 16'h0);
    reset_n = 1'b1;

    // T1: idle poll interval, latch width, nes_clk pulse count
    cyc = 0;
    do begin
      @(negedge clk);
      cyc++;
    end while (!bus.nes_latch && cyc < 40);
    check("t1_latch_delay", 16'(cyc), 16'd16);
    hi = 0;
    while (bus.nes_latch && hi < 40) begin
      hi++;
      @(negedge clk);
    end
    check("t1_latch_width", 16'(hi), 16'd4);
    prev = 1'b0;
    pul  = 0;
    got  = 1'b0;
    for (int i = 0; i < 2 * PER; i++) begin
      if (bus.buttons_valid) begin
        got = 1'b1;
        break;
      end
      if (bus.nes_clk && !prev) pul++;
      prev = bus.nes_clk;
      @(negedge clk);
    end
    check("t1_clk_pulses", 16'(pul), 16'd7);
    check("t1_valid_seen", 16'(got), 16'd1);
    check("t1_buttons", bus.buttons, 16'h0);

    // T2: A only
    btn[0] = 8'h80;
    wait_update();
    check("t2_buttons", bus.buttons, 16'h0080);
    check("t2_pressed", bus.pressed, 16'h0080);
    check("t2_mux", 16'(bus.mux_select), 16'h0);

    // T3: B held for two frames
    btn[0] = 8'h40;
    wait_update();
    check("t3_pressed1", bus.pressed, 16'h0040);
    check("t3_mux1", 16'(bus.mux_select), 16'h1);
    wait_update();
    check("t3_pressed2", bus.pressed, 16'h0000);
    check("t3_mux2", 16'(bus.mux_select), 16'h1);

    // T4: A+B then release
    btn[0] = 8'hC0;
    wait_update();
    check("t4_buttons", bus.buttons, 16'h00C0);
    check("t4_mux", 16'(bus.mux_select), 16'h0);
    btn[0] = 8'h00;
    wait_update();
    check("t4_release", bus.buttons, 16'h0000);
    check("t4_mux_hold", 16'(bus.mux_select), 16'h0);

    // T5: Select held three frames, released, pressed again
    btn[0] = 8'h20;
    for (int f = 0; f < 3; f++) begin
      wait_update();
      check("t5_sel_held", 16'(bus.select_out), 16'h1);
    end
    btn[0] = 8'h00;
    wait_update();
    check("t5_sel_rel", 16'(bus.select_out), 16'h1);
    btn[0] = 8'h20;
    wait_update();
    check("t5_sel_again", 16'(bus.select_out), 16'h0);

    // T6: second pad attached, reset pulsed during CLK_HI
    conn   = 2'b11;
    btn[0] = 8'h10;
    btn[1] = 8'h09;
    cyc = 0;
    while (!bus.nes_clk && cyc < 2 * PER) begin
      @(negedge clk);
      cyc++;
    end
    check("t6_clk_seen", 16'(bus.nes_clk), 16'h1);
    #2;
    reset_n = 1'b0;
    #1;
    check("t6_latch_drop", 16'(bus.nes_latch), 16'h0);
    check("t6_clk_drop", 16'(bus.nes_clk), 16'h0);
    check("t6_buttons_clr", bus.buttons, 16'h0);
    repeat (3) @(negedge clk);
    reset_n = 1'b1;
    wait_update();
    check("t6_buttons", bus.buttons, 16'h0910);
    check("t6_pressed", bus.pressed, 16'h0910);

    // Randomized frames; the model checks every cycle
    for (int f = 0; f < 40; f++) begin
      if ($urandom_range(0, 7) == 0) conn = 2'($urandom);
      if ($urandom_range(0, 2) != 0) begin
        btn[0] = 8'($urandom);
        btn[1] = 8'($urandom);
      end
      wait_update();
    end

    repeat (5) @(negedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
